branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. A lookup is answered one cycle after it is issued.
//   Resolved branches train the table at the end of their cycle. A lookup
//   that targets the same entry as a same-cycle update sees the old contents.
//
// Optional feature macro: BRANCH_PREDICTOR_STATS_EN
//   defined   -> saturating lookup / mispredict counters are maintained
//   undefined -> both counters read as 0 and upd_mispredict_i is ignored
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   fetch_valid_i     lookup request for fetch_pc_i this cycle
//   fetch_pc_i        PC to predict
//   flush_i           kills the lookup issued this cycle
//   pred_valid_o      registered prediction valid
//   pred_taken_o      predicted direction
//   pred_target_o     predicted next PC
//   upd_valid_i       a branch resolved this cycle
//   upd_pc_i          PC of the resolved branch
//   upd_uncond_i      resolved branch is JAL/JALR
//   upd_taken_i       actual direction
//   upd_target_i      actual target
//   upd_mispredict_i  resolution flagged a mispredict
//   lookup_cnt_o      number of accepted lookups (stats build only)
//   mispredict_cnt_o  number of reported mispredicts (stats build only)

module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    input  logic [63:0] fetch_pc_i,
    input  logic        flush_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [63:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [63:0] upd_pc_i,
    input  logic        upd_uncond_i,
    input  logic        upd_taken_i,
    input  logic [63:0] upd_target_i,
    input  logic        upd_mispredict_i,
    output logic [31:0] lookup_cnt_o,
    output logic [31:0] mispredict_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = TAG_W + IDX_W + 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] uncond_q, uncond_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [63:0]        target_q [ENTRIES];
    logic [63:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d [ENTRIES];

    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic [63:0] pred_target_q, pred_target_d;

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;
    logic             fetch_hit, upd_hit;
    logic [1:0]       upd_ctr;

    // Low PC bits are the instruction offset and high bits beyond the tag are
    // not stored; they are intentionally dropped for the update path.
    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc_i[63:TAG_HI+1], upd_pc_i[1:0]};

    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign fetch_tag = fetch_pc_i[TAG_HI:TAG_LO];
    assign upd_idx   = upd_pc_i[IDX_W+1:2];
    assign upd_tag   = upd_pc_i[TAG_HI:TAG_LO];
    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr   = ctr_q[upd_idx];

    // Table training. Taken branches allocate on a miss (starting weak-taken);
    // not-taken branches only weaken an existing entry and never allocate.
    always_comb begin
        valid_d  = valid_q;
        uncond_d = uncond_q;
        for (int i = 0; i < ENTRIES; i++) begin
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
        end
        if (upd_valid_i) begin
            if (upd_taken_i) begin
                target_d[upd_idx] = upd_target_i;
                uncond_d[upd_idx] = upd_uncond_i;
                if (upd_hit) begin
                    if (upd_ctr != 2'b11) begin
                        ctr_d[upd_idx] = upd_ctr + 2'd1;
                    end
                end else begin
                    valid_d[upd_idx] = 1'b1;
                    tag_d[upd_idx]   = upd_tag;
                    ctr_d[upd_idx]   = 2'b10;
                end
            end else if (upd_hit && (upd_ctr != 2'b00)) begin
                ctr_d[upd_idx] = upd_ctr - 2'd1;
            end
        end
    end

    // Prediction reads the registered table, so a same-cycle update is not
    // visible yet. Idle cycles keep the last direction/target on the outputs.
    always_comb begin
        pred_valid_d  = 1'b0;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (fetch_valid_i) begin
            pred_valid_d = !flush_i;
            if (fetch_hit && (uncond_q[fetch_idx] || ctr_q[fetch_idx][1])) begin
                pred_taken_d  = 1'b1;
                pred_target_d = target_q[fetch_idx];
            end else begin
                pred_taken_d  = 1'b0;
                pred_target_d = fetch_pc_i + 64'd4;
            end
        end
    end

    // Reset wins over any coincident lookup or update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            uncond_q      <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q       <= valid_d;
            uncond_q      <= uncond_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_target_o = pred_target_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] lookup_cnt_q, lookup_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // Both statistics counters stick at all-ones instead of wrapping.
    always_comb begin
        lookup_cnt_d     = lookup_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (fetch_valid_i && !flush_i && (lookup_cnt_q != 32'hFFFF_FFFF)) begin
            lookup_cnt_d = lookup_cnt_q + 32'd1;
        end
        if (upd_valid_i && upd_mispredict_i && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            lookup_cnt_q     <= lookup_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign lookup_cnt_o     = lookup_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = upd_mispredict_i;
    assign lookup_cnt_o      = '0;
    assign mispredict_cnt_o  = '0;
`endif

endmodule
